// File: rtl/mips_regfile_sb.sv
// MIPS general-purpose register file: NUM_RD registered read ports with write-through
// bypass, one write port, r0 hardwired to zero, and a pending-write scoreboard.
module mips_regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   output logic [NUM_RD-1:0]        rd_hazard,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [2**ADDR_W-1:0]     busy
);

   localparam int NREG = 2**ADDR_W;

   logic [NREG*DATA_W-1:0] file_flat;
   logic [NREG-1:0]        busy_reg;
   logic [NREG-1:0]        busy_next;
   logic                   rd_valid_reg;

   // Register storage; slot 0 has no storage so writes to r0 vanish.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign file_flat[0 +: DATA_W] = '0;
         end else begin : g_store
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
               if (rst)
                  q_reg <= '0;
               else if (wr_en && wr_addr == ADDR_W'(gi))
                  q_reg <= wr_data;
            end
            assign file_flat[gi*DATA_W +: DATA_W] = q_reg;
         end
      end
   endgenerate

   // Issue is applied after write-back so a same-cycle issue keeps the bit set.
   always_comb begin
      busy_next = busy_reg;
      if (wr_en)
         busy_next[wr_addr] = 1'b0;
      if (iss_en)
         busy_next[iss_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg     <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         busy_reg     <= busy_next;
         rd_valid_reg <= rd_en;
      end
   end

   assign busy     = busy_reg;
   assign rd_valid = rd_valid_reg;

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic              bypass;
         logic [DATA_W-1:0] data_next;
         logic [DATA_W-1:0] data_reg;
         logic              hazard_next;
         logic              hazard_reg;

         assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
         assign bypass = wr_en && (wr_addr == addr);

         // Hazard uses pre-edge busy, so an issue this cycle never flags its own sources.
         always_comb begin
            data_next = file_flat[int'(addr)*DATA_W +: DATA_W];
            if (addr == '0)
               data_next = '0;
            else if (bypass)
               data_next = wr_data;
            hazard_next = (addr != '0) && busy_reg[addr] && !bypass;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg   <= '0;
               hazard_reg <= 1'b0;
            end else if (rd_en) begin
               data_reg   <= data_next;
               hazard_reg <= hazard_next;
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
         assign rd_hazard[gi]                = hazard_reg;
      end
   endgenerate

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb (default parameters) plus a randomized
// reference-model run on a NUM_RD=3, DATA_W=16 instance.
module tb_mips_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // default instance: DATA_W=32, ADDR_W=5, NUM_RD=2
   logic        rd_en = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic [1:0]  rd_hazard;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        iss_en = 1'b0;
   logic [4:0]  iss_addr = '0;
   logic [31:0] busy;

   // sweep instance: DATA_W=16, ADDR_W=5, NUM_RD=3
   logic        rd_en3 = 1'b0;
   logic [14:0] rd_addr3 = '0;
   logic [47:0] rd_data3;
   logic        rd_valid3;
   logic [2:0]  rd_hazard3;
   logic        wr_en3 = 1'b0;
   logic [4:0]  wr_addr3 = '0;
   logic [15:0] wr_data3 = '0;
   logic        iss_en3 = 1'b0;
   logic [4:0]  iss_addr3 = '0;
   logic [31:0] busy3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_regfile_sb u_dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_hazard(rd_hazard), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy)
   );

   mips_regfile_sb #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) u_dut3 (
      .clk(clk), .rst(rst), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
      .rd_valid(rd_valid3), .rd_hazard(rd_hazard3), .wr_en(wr_en3), .wr_addr(wr_addr3),
      .wr_data(wr_data3), .iss_en(iss_en3), .iss_addr(iss_addr3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("  ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
   endtask

   // reference model for the sweep instance
   logic [15:0] m_regs [32];
   logic [31:0] m_busy;
   logic [47:0] m_data;
   logic [2:0]  m_haz;
   logic        m_valid;

   initial begin
      // 1: reset state, then read of r16/r8
      #2;
      check("rst_rd_data", rd_data, 64'h0);
      check("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
      check("rst_busy", {32'h0, busy}, 64'h0);
      step();
      rst = 1'b0;
      step();
      rd_en = 1'b1; rd_addr = {5'd16, 5'd8};
      step();
      idle();
      check("t1_rd_data", rd_data, 64'h0);
      check("t1_rd_valid", {63'h0, rd_valid}, 64'h1);
      check("t1_hazard", {62'h0, rd_hazard}, 64'h0);

      // 2: write r17 then read; write r0 then read
      wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'hDEADBEEF;
      step();
      idle();
      check("t1_valid_drop", {63'h0, rd_valid}, 64'h0);
      rd_en = 1'b1; rd_addr = {5'd0, 5'd17};
      step();
      idle();
      check("t2_r17", rd_data, {32'h0, 32'hDEADBEEF});
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      step();
      idle();
      rd_en = 1'b1; rd_addr = {5'd0, 5'd0};
      step();
      idle();
      check("t2_r0", rd_data, 64'h0);

      // 3: same-cycle write and read of r9 on both ports
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      rd_en = 1'b1; rd_addr = {5'd9, 5'd9};
      step();
      idle();
      check("t3_bypass", rd_data, {32'hA5A5A5A5, 32'hA5A5A5A5});
      check("t3_hazard", {62'h0, rd_hazard}, 64'h0);
      step();
      check("t3_hold", rd_data, {32'hA5A5A5A5, 32'hA5A5A5A5});

      // 4: scoreboard
      iss_en = 1'b1; iss_addr = 5'd10;
      step();
      idle();
      check("t4_busy10", {63'h0, busy[10]}, 64'h1);
      rd_en = 1'b1; rd_addr = {5'd0, 5'd10};
      step();
      idle();
      check("t4_hazard", {62'h0, rd_hazard}, 64'h1);
      rd_en = 1'b1; rd_addr = {5'd0, 5'd10};
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
      step();
      idle();
      check("t4_wb_hazard", {62'h0, rd_hazard}, 64'h0);
      check("t4_wb_data", rd_data, 64'h77);
      check("t4_wb_busy", {32'h0, busy}, 64'h0);
      iss_en = 1'b1; iss_addr = 5'd10;
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h88;
      step();
      idle();
      check("t4_set_wins", {32'h0, busy}, 64'h400);
      iss_en = 1'b1; iss_addr = 5'd11;
      rd_en = 1'b1; rd_addr = {5'd11, 5'd0};
      step();
      idle();
      check("t4_iss_rd_haz", {62'h0, rd_hazard}, 64'h0);
      check("t4_iss_rd_busy", {32'h0, busy}, 64'hC00);
      wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h11;
      step();
      wr_addr = 5'd10; wr_data = 32'h10;
      step();
      idle();
      check("t4_clear", {32'h0, busy}, 64'h0);

      // 5: load r8..r12, mark them busy, then asynchronous reset mid-cycle
      for (int a = 8; a <= 12; a++) begin
         wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h100 + 32'(a);
         step();
      end
      idle();
      for (int a = 8; a <= 12; a++) begin
         iss_en = 1'b1; iss_addr = 5'(a);
         step();
      end
      idle();
      rd_en = 1'b1; rd_addr = {5'd9, 5'd8};
      step();
      check("t5_pre_busy", {32'h0, busy}, 64'h1F00);
      check("t5_pre_data", rd_data, {32'h109, 32'h108});
      check("t5_pre_haz", {62'h0, rd_hazard}, 64'h3);
      #3 rst = 1'b1;
      #1;
      check("t5_async_busy", {32'h0, busy}, 64'h0);
      check("t5_async_data", rd_data, 64'h0);
      check("t5_async_valid", {63'h0, rd_valid}, 64'h0);
      check("t5_async_haz", {62'h0, rd_hazard}, 64'h0);
      #2 rst = 1'b0;
      rd_en = 1'b1; rd_addr = {5'd9, 5'd8};
      step();
      idle();
      check("t5_post_data", rd_data, 64'h0);
      check("t5_post_valid", {63'h0, rd_valid}, 64'h1);
      check("t5_post_haz", {62'h0, rd_hazard}, 64'h0);

      // 6: randomized run of the NUM_RD=3 / DATA_W=16 instance against a model
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0; m_data = '0; m_haz = '0; m_valid = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         logic [31:0] nb;
         rd_en3    = 1'($urandom_range(0, 1));
         rd_addr3  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_en3    = 1'($urandom_range(0, 1));
         wr_addr3  = 5'($urandom_range(0, 7));
         wr_data3  = 16'($urandom);
         iss_en3   = 1'($urandom_range(0, 1));
         iss_addr3 = 5'($urandom_range(0, 7));
         if (rd_en3) begin
            for (int p = 0; p < 3; p++) begin
               logic [4:0] a;
               logic       byp;
               a   = rd_addr3[p*5 +: 5];
               byp = wr_en3 && (wr_addr3 == a);
               m_data[p*16 +: 16] = (a == 0) ? 16'h0 : (byp ? wr_data3 : m_regs[a]);
               m_haz[p]           = (a != 0) && m_busy[a] && !byp;
            end
         end
         m_valid = rd_en3;
         nb = m_busy;
         if (wr_en3) nb[wr_addr3] = 1'b0;
         if (iss_en3) nb[iss_addr3] = 1'b1;
         nb[0] = 1'b0;
         m_busy = nb;
         if (wr_en3 && wr_addr3 != 0) m_regs[wr_addr3] = wr_data3;
         step();
         check($sformatf("t6_c%0d_data", cyc), {16'h0, rd_data3}, {16'h0, m_data});
         check($sformatf("t6_c%0d_haz", cyc), {61'h0, rd_hazard3}, {61'h0, m_haz});
         check($sformatf("t6_c%0d_valid", cyc), {63'h0, rd_valid3}, {63'h0, m_valid});
         check($sformatf("t6_c%0d_busy", cyc), {32'h0, busy3}, {32'h0, m_busy});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
